ex_stage_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the EX stage and the EX/MEM register of the pipelined MIPS core.

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/fp_latency_counter.sv | 39 +++
 rtl/ex_stage_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_ex_stage_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  pipeline_ctrl_pkg
//  Shared encodings for the EX-stage hazard controller: FP sequencer states,
//  FP operation codes and default FPU latencies.
//  Ports: none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FP_EXEC = 2'd1,
    ST_FP_DONE = 2'd2
  } fp_state_t;

  localparam logic [1:0] FP_ADD = 2'b00;
  localparam logic [1:0] FP_SUB = 2'b01;
  localparam logic [1:0] FP_MUL = 2'b10;
  localparam logic [1:0] FP_DIV = 2'b11;

  localparam int DEF_ADD_LAT = 3;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 12;
  localparam int DEF_CNT_W   = 4;

endpackage
`default_nettype wire

// File: rtl/fp_latency_counter.sv
`default_nettype none
// ============================================================================
//  fp_latency_counter
//  Down-counter for the FP sequencer: parallel load, decrement, zero detect.
//  Ports:
//    clk, reset (async active-low)
//    load      - load load_val (has priority over dec)
//    load_val  - value to load (latency - 1)
//    dec       - decrement; saturates at zero
//    cnt       - current count
//    zero      - cnt == 0
//  Revision: 1.0 - initial release
// ============================================================================
module fp_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ex_stage_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  ex_stage_hazard_ctrl
//  EX-stage sequencer: stalls the front end for multi-cycle FP ops, inserts a
//  bubble on load-use, and flushes IF/ID + ID/EX on a taken branch in EX/MEM.
//  Ports:
//    clk, reset (async active-low)
//    id_ex_*          - decoded info of the instruction in ID/EX
//    if_id_rs/rt      - source registers of the instruction in IF/ID
//    ex_mem_branch/zero_flag - taken-branch detect in EX/MEM
//    pc_write, if_id_write, id_ex_write - pipeline register load enables
//    if_id_flush, id_ex_bubble, ex_mem_bubble - squash controls
//    fpu_start, fpu_op - FPU launch pulse and operation
//    fp_busy          - FP op in progress
//  Revision: 1.0 - initial release
// ============================================================================
module ex_stage_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_ex_valid,
  input  logic       id_ex_fp,
  input  logic [1:0] id_ex_fp_op,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       ex_mem_branch,
  input  logic       ex_mem_zero_flag,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_bubble,
  output logic       ex_mem_bubble,
  output logic       fpu_start,
  output logic [1:0] fpu_op,
  output logic       fp_busy
);

  // Counter reload values: the start cycle already counts as one FPU cycle.
  localparam logic [CNT_W-1:0] ADD_LD = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  fp_state_t        state;
  fp_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_ld;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             flush;
  logic             load_use;

  assign flush = ex_mem_branch & ex_mem_zero_flag;

  assign load_use = id_ex_valid & id_ex_mem_read & (id_ex_rt != 5'd0) &
                    ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

  always_comb begin
    case (id_ex_fp_op)
      FP_ADD, FP_SUB: lat_ld = ADD_LD;
      FP_MUL:         lat_ld = MUL_LD;
      default:        lat_ld = DIV_LD;
    endcase
  end

  fp_latency_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (lat_ld),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    fpu_start     = 1'b0;
    fp_busy       = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    case (state)
      ST_IDLE: begin
        // reset gates the launch so no start pulse leaks out while in reset
        if (reset && id_ex_valid && id_ex_fp && !flush) begin
          fpu_start     = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_load      = 1'b1;
          state_next    = ST_FP_EXEC;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      ST_FP_EXEC: begin
        fp_busy       = 1'b1;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
        cnt_dec       = 1'b1;
        if (cnt_zero) begin
          state_next = ST_FP_DONE;
        end
      end
      ST_FP_DONE: begin
        // result is captured into EX/MEM; the FP instruction leaves ID/EX now
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (flush) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  assign fpu_op = fpu_start ? id_ex_fp_op : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_ex_stage_hazard_ctrl
//  Self-checking bench: directed hazard scenarios plus random stimulus, all
//  compared cycle by cycle against a cycles-remaining reference model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ex_stage_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_ex_valid, id_ex_fp, id_ex_mem_read;
  logic [1:0] id_ex_fp_op;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       ex_mem_branch, ex_mem_zero_flag;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write;
  logic       id_ex_bubble, ex_mem_bubble, fpu_start, fp_busy;
  logic [1:0] fpu_op;

  int total = 0;
  int bad   = 0;

  // Reference model: FP cycles still to spend stalled, and "result cycle next".
  int fp_left = 0;
  bit done_f  = 1'b0;

  // last sampled values
  logic s_pc_write, s_fpu_start, s_ex_mem_bubble, s_id_ex_write, s_id_ex_bubble;

  always #5 clk = ~clk;

  ex_stage_hazard_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .id_ex_valid      (id_ex_valid),
    .id_ex_fp         (id_ex_fp),
    .id_ex_fp_op      (id_ex_fp_op),
    .id_ex_mem_read   (id_ex_mem_read),
    .id_ex_rt         (id_ex_rt),
    .if_id_rs         (if_id_rs),
    .if_id_rt         (if_id_rt),
    .ex_mem_branch    (ex_mem_branch),
    .ex_mem_zero_flag (ex_mem_zero_flag),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_write      (id_ex_write),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_bubble    (ex_mem_bubble),
    .fpu_start        (fpu_start),
    .fpu_op           (fpu_op),
    .fp_busy          (fp_busy)
  );

  // A taken branch cannot reach EX/MEM while an FP op is sequencing.
  always @(negedge clk) begin
    if (reset) begin
      assert (!(ex_mem_branch && ex_mem_zero_flag && fp_busy))
        else $error("flush while FP busy");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b10:   return 4;
      2'b11:   return 12;
      default: return 3;
    endcase
  endfunction

  task automatic set_idle();
    id_ex_valid = 0; id_ex_fp = 0; id_ex_fp_op = 0; id_ex_mem_read = 0;
    id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    ex_mem_branch = 0; ex_mem_zero_flag = 0;
  endtask

  task automatic assert_reset();
    reset   = 1'b0;
    fp_left = 0;
    done_f  = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance model.
  task automatic cycle();
    bit in_exec, in_done, flush, start, lu;
    @(negedge clk);
    in_exec = (fp_left > 0);
    in_done = done_f;
    flush   = ex_mem_branch & ex_mem_zero_flag;
    start   = reset & !in_exec & !in_done & id_ex_valid & id_ex_fp & !flush;
    lu      = !in_exec & !in_done & !start & id_ex_valid & id_ex_mem_read &
              (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
    check("pc_write",      pc_write,      !(start | in_exec | lu));
    check("if_id_write",   if_id_write,   !(start | in_exec | lu));
    check("id_ex_write",   id_ex_write,   !(start | in_exec));
    check("if_id_flush",   if_id_flush,   flush);
    check("id_ex_bubble",  id_ex_bubble,  flush | lu);
    check("ex_mem_bubble", ex_mem_bubble, start | in_exec);
    check("fpu_start",     fpu_start,     start);
    check("fpu_op",        fpu_op,        start ? id_ex_fp_op : 2'b00);
    check("fp_busy",       fp_busy,       in_exec);
    s_pc_write      = pc_write;
    s_fpu_start     = fpu_start;
    s_ex_mem_bubble = ex_mem_bubble;
    s_id_ex_write   = id_ex_write;
    s_id_ex_bubble  = id_ex_bubble;
    @(posedge clk);
    if (reset) begin
      if (in_exec) begin
        fp_left--;
        if (fp_left == 0) done_f = 1'b1;
      end else if (in_done) begin
        done_f = 1'b0;
      end else if (start) begin
        fp_left = lat_of(id_ex_fp_op);
      end
    end
    #1;
  endtask

  initial begin
    int stalls, starts;
    set_idle();
    assert_reset();

    // 1. reset low with random inputs
    for (int i = 0; i < 6; i++) begin
      id_ex_valid = 1'($urandom); id_ex_fp = 1'($urandom);
      id_ex_fp_op = 2'($urandom); id_ex_mem_read = 1'($urandom);
      id_ex_rt = 5'($urandom_range(0, 3)); if_id_rs = 5'($urandom_range(0, 3));
      if_id_rt = 5'($urandom_range(0, 3));
      ex_mem_branch = 1'($urandom); ex_mem_zero_flag = 1'($urandom);
      cycle();
      check("rst_busy", fp_busy, 1'b0);
      check("rst_start", fpu_start, 1'b0);
    end
    set_idle();
    reset = 1'b1;
    cycle();
    check("post_rst_pc", s_pc_write, 1'b1);
    check("post_rst_bub", s_ex_mem_bubble | s_id_ex_bubble, 1'b0);

    // 2. FP add: start pulse once, 4 stall cycles, then result cycle
    id_ex_valid = 1; id_ex_fp = 1; id_ex_fp_op = 2'b00;
    stalls = 0; starts = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      stalls += (s_pc_write == 1'b0) ? 1 : 0;
      starts += s_fpu_start ? 1 : 0;
    end
    check("add_stalls", stalls, 4);
    check("add_starts", starts, 1);
    cycle();
    check("add_done_pc", s_pc_write, 1'b1);
    check("add_done_idw", s_id_ex_write, 1'b1);
    check("add_done_exb", s_ex_mem_bubble, 1'b0);
    set_idle();
    cycle();

    // 3. div then mul back-to-back
    id_ex_valid = 1; id_ex_fp = 1; id_ex_fp_op = 2'b11;
    stalls = 0; starts = 0;
    for (int i = 0; i < 19; i++) begin
      if (i == 13) id_ex_fp_op = 2'b10;
      cycle();
      if (i == 13) check("b2b_free", s_pc_write, 1'b1);
      if (i == 0 || i == 14) check("b2b_start_pos", s_fpu_start, 1'b1);
      stalls += (s_pc_write == 1'b0) ? 1 : 0;
      starts += s_fpu_start ? 1 : 0;
    end
    check("b2b_stalls", stalls, 18);
    check("b2b_starts", starts, 2);
    cycle();
    check("b2b_mul_done", s_pc_write, 1'b1);
    set_idle();
    cycle();

    // 4. load-use: rt=5 against rs=5, then rt=0
    id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rt = 5; if_id_rs = 5; if_id_rt = 7;
    cycle();
    check("lu_pc", s_pc_write, 1'b0);
    check("lu_bub", s_id_ex_bubble, 1'b1);
    set_idle();
    if_id_rs = 5;
    cycle();
    check("lu_after_pc", s_pc_write, 1'b1);
    id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    cycle();
    check("lu_r0_pc", s_pc_write, 1'b1);
    check("lu_r0_bub", s_id_ex_bubble, 1'b0);
    set_idle();

    // 5. taken branch while FP op waits in ID/EX
    id_ex_valid = 1; id_ex_fp = 1; id_ex_fp_op = 2'b10;
    ex_mem_branch = 1; ex_mem_zero_flag = 1;
    cycle();
    check("fl_flush", if_id_flush, 1'b1);
    check("fl_bub", s_id_ex_bubble, 1'b1);
    check("fl_nostart", s_fpu_start, 1'b0);
    set_idle();
    cycle();

    // 6. reset in the 6th cycle of a div
    id_ex_valid = 1; id_ex_fp = 1; id_ex_fp_op = 2'b11;
    for (int i = 0; i < 5; i++) cycle();
    check("div_busy_pre", fp_busy, 1'b1);
    assert_reset();
    #1;
    check("mid_rst_busy", fp_busy, 1'b0);
    check("mid_rst_pc", pc_write, 1'b1);
    check("mid_rst_start", fpu_start, 1'b0);
    cycle();
    set_idle();
    reset = 1'b1;
    cycle();
    check("rel_pc", s_pc_write, 1'b1);
    check("rel_idw", s_id_ex_write, 1'b1);

    // random stimulus; taken branches only when no FP op is sequencing
    for (int i = 0; i < 400; i++) begin
      id_ex_valid    = ($urandom_range(0, 4) != 0);
      id_ex_fp       = ($urandom_range(0, 5) == 0);
      id_ex_fp_op    = 2'($urandom);
      id_ex_mem_read = ($urandom_range(0, 2) == 0);
      id_ex_rt       = 5'($urandom_range(0, 3));
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      ex_mem_branch  = 1'($urandom);
      ex_mem_zero_flag = (fp_left == 0 && !done_f) ? ($urandom_range(0, 3) == 0) : 1'b0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
